// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for mem_ctrl: size encodings, FSM states,
// byte-lane merge masks and load extension.
package mem_ctrl_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [0:0] {ST_IDLE, ST_RD} state_t;

    // The reserved encoding behaves exactly like a word access.
    function automatic logic is_word(input logic [1:0] size);
        return (size != SZ_HALF) && (size != SZ_BYTE);
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_HALF: return lane[0];
            SZ_BYTE: return 1'b0;
            default: return lane != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 4'b0001 << lane;
            SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the store data so every candidate lane carries the new value.
    function automatic logic [31:0] lane_spread(input logic [1:0] size, input logic [31:0] data);
        case (size)
            SZ_BYTE: return {4{data[7:0]}};
            SZ_HALF: return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic sext, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: return {{24{sext & b[7]}}, b};
            SZ_HALF: return {{16{sext & h[15]}}, h};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response bundle between the control unit (master) and mem_ctrl (slave).
interface mem_ctrl_if;
    import mem_ctrl_pkg::*;

    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    modport master (output req, we, size, sext, addr, wdata,
                    input  rdata, ready, err, busy);
    modport slave  (input  req, we, size, sext, addr, wdata,
                    output rdata, ready, err, busy);
endinterface

// File: rtl/mem_word_ram.sv
// Single-port DEPTH x 32 synchronous RAM with one-cycle registered read.
module mem_word_ram #(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);
    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_reg <= mem[addr];
    end

    assign rdata = rdata_reg;
endmodule

// File: rtl/mem_ctrl.sv
// Memory responder: word stores in one cycle, loads and sub-word stores via a RAM read.
// Build option: MEM_ALIGN_CHECK_EN rejects misaligned half/word accesses with err.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic      clk,
    input  logic      reset,
    mem_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    state_t        state_reg, state_next;
    logic          we_reg;
    logic [1:0]    size_reg;
    logic          sext_reg;
    logic [1:0]    lane_reg;
    logic [31:0]   wdata_reg;
    logic [AW-1:0] idx_reg;
    logic [31:0]   rdata_reg, rdata_next;
    logic          ready_reg, ready_next;
    logic          err_reg, err_next;
    logic          busy_reg;

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [31:0]   ram_wdata, ram_rdata;
    logic          misaligned;
    logic [3:0]    merge_mask;
    logic [31:0]   merge_src, merged;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = is_misaligned(bus.size, bus.addr[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign merge_mask = lane_mask(size_reg, lane_reg);
    assign merge_src  = lane_spread(size_reg, wdata_reg);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign merged[gi*8 +: 8] = merge_mask[gi] ? merge_src[gi*8 +: 8] : ram_rdata[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        rdata_next = rdata_reg;
        ready_next = 1'b0;
        err_next   = 1'b0;
        ram_addr   = bus.addr[AW+1:2];
        ram_we     = 1'b0;
        ram_wdata  = bus.wdata;
        case (state_reg)
            ST_IDLE: begin
                if (bus.req) begin
                    if (misaligned) begin
                        ready_next = 1'b1;
                        err_next   = 1'b1;
                    end else if (bus.we && is_word(bus.size)) begin
                        ram_we     = 1'b1;
                        ready_next = 1'b1;
                    end else begin
                        state_next = ST_RD;
                    end
                end
            end
            default: begin
                // RAM output now holds the word addressed in IDLE.
                ram_addr   = idx_reg;
                ready_next = 1'b1;
                state_next = ST_IDLE;
                if (we_reg) begin
                    ram_we    = 1'b1;
                    ram_wdata = merged;
                end else begin
                    rdata_next = load_extend(ram_rdata, size_reg, sext_reg, lane_reg);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            rdata_reg <= '0;
            ready_reg <= 1'b0;
            err_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            rdata_reg <= rdata_next;
            ready_reg <= ready_next;
            err_reg   <= err_next;
            busy_reg  <= (state_next == ST_RD);
        end
    end

    // Request fields are only consumed in RD, so capturing every IDLE cycle is harmless.
    always_ff @(posedge clk) begin
        if (state_reg == ST_IDLE) begin
            we_reg    <= bus.we;
            size_reg  <= bus.size;
            sext_reg  <= bus.sext;
            lane_reg  <= bus.addr[1:0];
            wdata_reg <= bus.wdata;
            idx_reg   <= bus.addr[AW+1:2];
        end
    end

    // Gating with reset keeps an aborted sub-word store out of the RAM.
    mem_word_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (ram_we & reset),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign bus.rdata = rdata_reg;
    assign bus.ready = ready_reg;
    assign bus.err   = err_reg;
    assign bus.busy  = busy_reg;
endmodule
